// File: rtl/atpg_pkg.sv
// Shared types and constants for the ATPG vector player and its MISR.
// Latency: n/a (types, constants and an elaboration-time helper only).
// Backpressure: n/a.
package atpg_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_APPLY   = 3'd1,
        ST_SETTLE  = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

    // CRC-32 taps; the usual MISR feedback polynomial.
    localparam logic [31:0] MISR_POLY_DEFAULT = 32'h04C11DB7;

    // Ceiling log2. The result is never below 1, so an index or counter
    // built from it always has at least one bit.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << r) < value) r = r + 1;
        end
        if (r < 1) r = 1;
        return r;
    endfunction

endpackage

// File: rtl/atpg_misr.sv
// Multiple-input signature register: folds each response into SIG_W bits and shifts it into an LFSR.
// Latency: the signature is updated on the edge where en is high; clr clears it on the next edge.
// Backpressure: none; every enabled cycle is absorbed.
module atpg_misr
    import atpg_pkg::*;
#(
    parameter int              SIG_W = 32,
    parameter int              OUT_W = 140,
    parameter logic [SIG_W-1:0] POLY = SIG_W'(MISR_POLY_DEFAULT)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic [OUT_W-1:0] din,
    output logic [SIG_W-1:0] sig
);

    localparam int NCHUNK = (OUT_W + SIG_W - 1) / SIG_W;

    logic [NCHUNK*SIG_W-1:0] din_pad;
    logic [SIG_W-1:0]        fold;
    logic [SIG_W-1:0]        sig_next;

    // Zero-extend the response to a whole number of chunks and XOR the chunks together.
    always_comb begin
        din_pad              = '0;
        din_pad[OUT_W-1:0]   = din;
        fold                 = '0;
        for (int i = 0; i < NCHUNK; i++) begin
            fold = fold ^ din_pad[i*SIG_W +: SIG_W];
        end
    end

    // Galois-style shift with feedback on the outgoing MSB, then mix in the folded response.
    always_comb begin
        sig_next = {sig[SIG_W-2:0], 1'b0} ^ (sig[SIG_W-1] ? POLY : '0) ^ fold;
    end

    // Signature register; clear wins over an update in the same cycle.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            sig <= '0;
        end else if (en) begin
            sig <= sig_next;
        end
    end

endmodule

// File: rtl/atpg_vector_player.sv
// Replays stored stimulus vectors into a DUT, captures and compares responses, and builds a MISR signature.
// Latency: SETTLE+2 cycles per vector; done rises on the edge that captures the last vector.
// Backpressure: start and slot loads are ignored while busy; no stall input, the run is free-running.
module atpg_vector_player
    import atpg_pkg::*;
#(
    parameter int               IN_W   = 233,
    parameter int               OUT_W  = 140,
    parameter int               DEPTH  = 16,
    parameter int               SETTLE = 1,
    parameter int               SIG_W  = 32,
    parameter logic [SIG_W-1:0] POLY   = SIG_W'(MISR_POLY_DEFAULT)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        ld_en,
    input  logic [clog2(DEPTH)-1:0]     ld_addr,
    input  logic [IN_W-1:0]             ld_stim,
    input  logic [OUT_W-1:0]            ld_exp,
    input  logic [clog2(DEPTH+1)-1:0]   vec_count,
    input  logic                        cmp_en,
    input  logic                        start,
    output logic                        busy,
    output logic                        done,
    output logic [IN_W-1:0]             dut_in,
    input  logic [OUT_W-1:0]            dut_out,
    input  logic [clog2(DEPTH)-1:0]     rd_addr,
    output logic [OUT_W-1:0]            rd_data,
    output logic [clog2(DEPTH+1)-1:0]   fail_cnt,
    output logic                        any_fail,
    output logic [clog2(DEPTH)-1:0]     first_fail,
    output logic [SIG_W-1:0]            signature
);

    localparam int AW = clog2(DEPTH);
    localparam int CW = clog2(DEPTH + 1);
    localparam int SW = clog2(SETTLE + 1);

    state_t state_q, state_d;

    logic [IN_W-1:0]  stim_mem [DEPTH];
    logic [OUT_W-1:0] exp_mem  [DEPTH];
    logic [OUT_W-1:0] resp_mem [DEPTH];

    logic [IN_W-1:0]  stim_q;
    logic [OUT_W-1:0] exp_q;
    logic             applied;
    logic [AW-1:0]    k;
    logic [CW-1:0]    cnt_q;
    logic [CW-1:0]    cnt_in;
    logic             cmp_q;
    logic [SW-1:0]    settle_cnt;
    logic             start_acc;
    logic             last_vec;
    logic             capture;
    logic             mismatch;

    assign cnt_in    = (vec_count > CW'(DEPTH)) ? CW'(DEPTH) : vec_count;
    assign start_acc = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    assign last_vec  = (CW'(k) + CW'(1)) == cnt_q;
    assign capture   = (state_q == ST_CAPTURE);
    assign mismatch  = cmp_q && (dut_out != exp_q);

    // dut_in reads zero after reset until the first vector of a run is applied, then holds it.
    assign dut_in = applied ? stim_q : '0;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: apply, wait SETTLE cycles, capture, repeat until the latched count is used up.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) state_d = (cnt_in == '0) ? ST_DONE : ST_APPLY;
            end
            ST_APPLY:   state_d = ST_SETTLE;
            ST_SETTLE:  if (settle_cnt == SW'(SETTLE - 1)) state_d = ST_CAPTURE;
            ST_CAPTURE: state_d = last_vec ? ST_DONE : ST_APPLY;
            default:    state_d = ST_IDLE;
        endcase
    end

    // Outputs decoded from state.
    always_comb begin
        busy = (state_q == ST_APPLY) || (state_q == ST_SETTLE) || (state_q == ST_CAPTURE);
    end

    // Run bookkeeping: vector index, settle timer, compare results and done flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            applied    <= 1'b0;
            k          <= '0;
            cnt_q      <= '0;
            cmp_q      <= 1'b0;
            settle_cnt <= '0;
            fail_cnt   <= '0;
            any_fail   <= 1'b0;
            first_fail <= '0;
            done       <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        cnt_q      <= cnt_in;
                        cmp_q      <= cmp_en;
                        fail_cnt   <= '0;
                        any_fail   <= 1'b0;
                        first_fail <= '0;
                        k          <= '0;
                        done       <= 1'b0;
                    end else if (state_q == ST_DONE) begin
                        // Covers the empty run, which enters DONE with done still low.
                        done <= 1'b1;
                    end
                end
                ST_APPLY: begin
                    applied    <= 1'b1;
                    settle_cnt <= '0;
                end
                ST_SETTLE: begin
                    settle_cnt <= settle_cnt + SW'(1);
                end
                ST_CAPTURE: begin
                    if (mismatch) begin
                        fail_cnt <= fail_cnt + CW'(1);
                        any_fail <= 1'b1;
                        if (!any_fail) first_fail <= k;
                    end
                    if (last_vec) begin
                        done <= 1'b1;
                    end else begin
                        k <= k + AW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Slot loads; memory contents survive reset.
    always_ff @(posedge clk) begin
        if (ld_en && !busy && !rst) begin
            stim_mem[ld_addr] <= ld_stim;
            exp_mem[ld_addr]  <= ld_exp;
        end
    end

    // Registered reads of the current vector's stimulus and expected response.
    always_ff @(posedge clk) begin
        if (!rst && (state_q == ST_APPLY)) begin
            stim_q <= stim_mem[k];
            exp_q  <= exp_mem[k];
        end
    end

    // Response capture; a reset in the capture cycle drops the write.
    always_ff @(posedge clk) begin
        if (!rst && capture) begin
            resp_mem[k] <= dut_out;
        end
    end

    // Synchronous response read port, live in every state.
    always_ff @(posedge clk) begin
        rd_data <= resp_mem[rd_addr];
    end

    atpg_misr #(
        .SIG_W (SIG_W),
        .OUT_W (OUT_W),
        .POLY  (POLY)
    ) u_misr (
        .clk (clk),
        .rst (rst),
        .clr (start_acc),
        .en  (capture),
        .din (dut_out),
        .sig (signature)
    );

endmodule

// File: tb/tb_atpg_vector_player.sv
// Self-checking bench for atpg_vector_player with a small configuration and an inverting DUT model.
// Latency: checks the SETTLE+2 per-vector timing and the 1-cycle response read port.
// Backpressure: exercises starts and loads issued while busy, which must be dropped.
module tb_atpg_vector_player;

    logic       clk;
    logic       rst;
    logic       ld_en;
    logic [1:0] ld_addr;
    logic [7:0] ld_stim;
    logic [7:0] ld_exp;
    logic [2:0] vec_count;
    logic       cmp_en;
    logic       start;
    logic       busy;
    logic       done;
    logic [7:0] dut_in;
    logic [7:0] dut_out;
    logic [1:0] rd_addr;
    logic [7:0] rd_data;
    logic [2:0] fail_cnt;
    logic       any_fail;
    logic [1:0] first_fail;
    logic [7:0] signature;

    atpg_vector_player #(
        .IN_W   (8),
        .OUT_W  (8),
        .DEPTH  (4),
        .SETTLE (1),
        .SIG_W  (8),
        .POLY   (8'h1D)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .ld_en      (ld_en),
        .ld_addr    (ld_addr),
        .ld_stim    (ld_stim),
        .ld_exp     (ld_exp),
        .vec_count  (vec_count),
        .cmp_en     (cmp_en),
        .start      (start),
        .busy       (busy),
        .done       (done),
        .dut_in     (dut_in),
        .dut_out    (dut_out),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .fail_cnt   (fail_cnt),
        .any_fail   (any_fail),
        .first_fail (first_fail),
        .signature  (signature)
    );

    // Device under test: a plain inverter.
    assign dut_out = ~dut_in;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0][7:0] stim;
        logic [3:0][7:0] exp_w;
        logic [2:0]      count;
        logic            cmp;
        logic [2:0]      e_fail;
        logic            e_any;
        logic [1:0]      e_first;
        logic [7:0]      e_sig;
    } tv_t;

    localparam int NTV = 7;
    tv_t tbl [NTV];

    int errors = 0;
    int checks = 0;
    logic [7:0] last_dut_in;
    logic [7:0] stim_q [$];
    logic [7:0] resp_q [$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", nm, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_tv(input int i, input logic [31:0] s, input logic [31:0] e, input logic [2:0] cnt,
                          input logic c, input logic [2:0] ef, input logic ea, input logic [1:0] efi,
                          input logic [7:0] es);
        tbl[i].stim    = s;
        tbl[i].exp_w   = e;
        tbl[i].count   = cnt;
        tbl[i].cmp     = c;
        tbl[i].e_fail  = ef;
        tbl[i].e_any   = ea;
        tbl[i].e_first = efi;
        tbl[i].e_sig   = es;
    endtask

    task automatic load_mem(input int idx);
        for (int s = 0; s < 4; s++) begin
            ld_en   = 1'b1;
            ld_addr = 2'(s);
            ld_stim = tbl[idx].stim[s];
            ld_exp  = tbl[idx].exp_w[s];
            tick();
        end
        ld_en = 1'b0;
    endtask

    // One run: optional load, start, per-cycle timeline monitor, final results, response readback.
    task automatic run_case(input int idx, input bit do_load, input int inject);
        tv_t t;
        int n;
        int done_edge;
        int rises;
        bit busy_seen;
        logic prev_done;
        logic [7:0] e;
        t = tbl[idx];
        n = (int'(t.count) > 4) ? 4 : int'(t.count);
        if (do_load) load_mem(idx);
        for (int v = 0; v < n; v++) stim_q.push_back(t.stim[v]);

        vec_count = t.count;
        cmp_en    = t.cmp;
        start     = 1'b1;
        tick();
        start = 1'b0;
        chk($sformatf("tv%0d_done_clear", idx), 32'(done), 32'(0));
        chk($sformatf("tv%0d_busy_e0", idx), 32'(busy), 32'(n > 0));

        done_edge = -1;
        rises     = 0;
        busy_seen = 1'b0;
        prev_done = 1'b0;
        for (int c = 1; c <= 16; c++) begin
            if (c == inject) begin
                start   = 1'b1;
                ld_en   = 1'b1;
                ld_addr = 2'd0;
                ld_stim = 8'h55;
                ld_exp  = 8'hAA;
            end
            tick();
            if (c == inject) begin
                start = 1'b0;
                ld_en = 1'b0;
            end
            if (busy) busy_seen = 1'b1;
            if (done && !prev_done) begin
                rises++;
                if (done_edge < 0) done_edge = c;
            end
            prev_done = done;
            if (((c - 1) % 3 == 0) && ((c - 1) / 3 < n)) begin
                if (stim_q.size() == 0) begin
                    chk($sformatf("tv%0d_stim_q_empty", idx), 32'(1), 32'(0));
                end else begin
                    e = stim_q.pop_front();
                    chk($sformatf("tv%0d_dut_in_c%0d", idx, c), 32'(dut_in), 32'(e));
                end
            end
        end
        chk($sformatf("tv%0d_done_edge", idx), 32'(done_edge), 32'((n == 0) ? 1 : 3 * n));
        chk($sformatf("tv%0d_done_rises", idx), 32'(rises), 32'(1));
        chk($sformatf("tv%0d_busy_seen", idx), 32'(busy_seen), 32'(n > 0));
        chk($sformatf("tv%0d_fail_cnt", idx), 32'(fail_cnt), 32'(t.e_fail));
        chk($sformatf("tv%0d_any_fail", idx), 32'(any_fail), 32'(t.e_any));
        chk($sformatf("tv%0d_first_fail", idx), 32'(first_fail), 32'(t.e_first));
        chk($sformatf("tv%0d_signature", idx), 32'(signature), 32'(t.e_sig));
        if (n > 0) last_dut_in = t.stim[n-1];
        chk($sformatf("tv%0d_dut_in_hold", idx), 32'(dut_in), 32'(last_dut_in));

        for (int v = 0; v < n; v++) begin
            rd_addr = 2'(v);
            resp_q.push_back(~t.stim[v]);
            tick();
            e = resp_q.pop_front();
            chk($sformatf("tv%0d_resp%0d", idx, v), 32'(rd_data), 32'(e));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        ld_en     = 1'b0;
        ld_addr   = '0;
        ld_stim   = '0;
        ld_exp    = '0;
        vec_count = '0;
        cmp_en    = 1'b0;
        start     = 1'b0;
        rd_addr   = '0;
        last_dut_in = 8'h00;

        //      idx stim {s3,s2,s1,s0}  exp {e3,e2,e1,e0}  cnt cmp fail any first sig
        set_tv(0, 32'hFFAA0F00, 32'h0055F0FF, 3'd4, 1'b1, 3'd0, 1'b0, 2'd0, 8'hE6);
        set_tv(1, 32'hFFAA0F00, 32'h0054F0FF, 3'd4, 1'b1, 3'd1, 1'b1, 2'd2, 8'hE6);
        set_tv(2, 32'hFFAA0F00, 32'h0054F0FF, 3'd4, 1'b0, 3'd0, 1'b0, 2'd0, 8'hE6);
        set_tv(3, 32'hFFAA0F00, 32'h0055F0FF, 3'd0, 1'b1, 3'd0, 1'b0, 2'd0, 8'h00);
        set_tv(4, 32'hFFAA0F00, 32'h00000000, 3'd7, 1'b1, 3'd3, 1'b1, 2'd0, 8'hE6);
        set_tv(5, 32'h00008001, 32'h000000FE, 3'd2, 1'b1, 3'd1, 1'b1, 2'd1, 8'h9E);
        set_tv(6, 32'h0000003C, 32'h000000C3, 3'd1, 1'b1, 3'd0, 1'b0, 2'd0, 8'hC3);

        tick();
        tick();
        rst = 1'b0;
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_done", 32'(done), 32'(0));
        chk("rst_dut_in", 32'(dut_in), 32'(0));
        chk("rst_fail_cnt", 32'(fail_cnt), 32'(0));
        chk("rst_any_fail", 32'(any_fail), 32'(0));
        chk("rst_first_fail", 32'(first_fail), 32'(0));
        chk("rst_signature", 32'(signature), 32'(0));

        for (int i = 0; i < NTV; i++) run_case(i, 1'b1, -1);

        // Reset in the middle of vector 2, then a rerun from retained memory.
        load_mem(0);
        vec_count = 3'd4;
        cmp_en    = 1'b1;
        start     = 1'b1;
        tick();
        start = 1'b0;
        repeat (7) tick();
        chk("mid_dut_in_v2", 32'(dut_in), 32'(8'hAA));
        chk("mid_sig_nonzero", 32'(signature != 8'h00), 32'(1));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_busy", 32'(busy), 32'(0));
        chk("mid_rst_done", 32'(done), 32'(0));
        chk("mid_rst_dut_in", 32'(dut_in), 32'(0));
        chk("mid_rst_fail_cnt", 32'(fail_cnt), 32'(0));
        chk("mid_rst_signature", 32'(signature), 32'(0));
        last_dut_in = 8'h00;

        // Reset beats start and a slot load in the same cycle.
        rst     = 1'b1;
        start   = 1'b1;
        ld_en   = 1'b1;
        ld_addr = 2'd0;
        ld_stim = 8'h55;
        ld_exp  = 8'hAA;
        tick();
        rst   = 1'b0;
        start = 1'b0;
        ld_en = 1'b0;
        tick();
        chk("rst_prio_busy", 32'(busy), 32'(0));
        chk("rst_prio_dut_in", 32'(dut_in), 32'(0));
        run_case(0, 1'b0, -1);

        // Start and load issued while busy are dropped; a rerun shows slot 0 untouched.
        run_case(0, 1'b1, 4);
        run_case(0, 1'b0, -1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
